// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use hazard detection,
// flush/freeze handling and a saturating load-use bubble counter.
module id_ex_hazard_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rsrc1_i,
    input  logic [REG_AW-1:0] id_rsrc2_i,
    input  logic              id_use1_i,
    input  logic              id_use2_i,
    input  logic [REG_AW-1:0] id_rdst_i,
    input  logic              id_wb_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic [3:0]        id_alu_op_i,
    input  logic [DATA_W-1:0] id_op1_i,
    input  logic [DATA_W-1:0] id_op2_i,
    input  logic              flush_i,
    input  logic              freeze_i,
    output logic              stall_if_id_o,
    output logic              ex_valid_o,
    output logic              ex_wb_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic [REG_AW-1:0] ex_rsrc1_o,
    output logic [REG_AW-1:0] ex_rsrc2_o,
    output logic [REG_AW-1:0] ex_rdst_o,
    output logic [3:0]        ex_alu_op_o,
    output logic [DATA_W-1:0] ex_op1_o,
    output logic [DATA_W-1:0] ex_op2_o,
    output logic [CNT_W-1:0]  load_use_cnt_o
);
    logic              valid_q, valid_d, wb_q, wb_d, mr_q, mr_d, mw_q, mw_d;
    logic [REG_AW-1:0] rsrc1_q, rsrc1_d, rsrc2_q, rsrc2_d, rdst_q, rdst_d;
    logic [3:0]        alu_q, alu_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hz, bubble;

    assign hz = id_valid_i & valid_q & mr_q & wb_q &
                ((id_use1_i & (id_rsrc1_i == rdst_q)) | (id_use2_i & (id_rsrc2_i == rdst_q)));
    assign bubble        = flush_i | hz;
    assign stall_if_id_o = freeze_i | (hz & ~flush_i);

    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        rsrc1_d = rsrc1_q;
        rsrc2_d = rsrc2_q;
        rdst_d  = rdst_q;
        alu_d   = alu_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        if (!freeze_i) begin
            // control bits are gated by the resulting valid so bubbles and invalid slots carry no side effects
            valid_d = id_valid_i & ~bubble;
            wb_d    = id_wb_i & valid_d;
            mr_d    = id_mem_read_i & valid_d;
            mw_d    = id_mem_write_i & valid_d;
            rsrc1_d = id_rsrc1_i;
            rsrc2_d = id_rsrc2_i;
            rdst_d  = id_rdst_i;
            alu_d   = id_alu_op_i;
            op1_d   = id_op1_i;
            op2_d   = id_op2_i;
            cnt_d   = (hz & ~flush_i & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            rsrc1_q <= '0;
            rsrc2_q <= '0;
            rdst_q  <= '0;
            alu_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            rsrc1_q <= rsrc1_d;
            rsrc2_q <= rsrc2_d;
            rdst_q  <= rdst_d;
            alu_q   <= alu_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid_o     = valid_q;
    assign ex_wb_o        = wb_q;
    assign ex_mem_read_o  = mr_q;
    assign ex_mem_write_o = mw_q;
    assign ex_rsrc1_o     = rsrc1_q;
    assign ex_rsrc2_o     = rsrc2_q;
    assign ex_rdst_o      = rdst_q;
    assign ex_alu_op_o    = alu_q;
    assign ex_op1_o       = op1_q;
    assign ex_op2_o       = op2_q;
    assign load_use_cnt_o = cnt_q;
endmodule
